seq_arith_unit: RTL and testbench
=================================

Name: seq_arith_unit

Overview:
- Parametrised multi-cycle arithmetic unit: unsigned add, subtract, shift-add multiply and restoring divide on WIDTH-bit operands.
- Operands and operation are captured on a start/done handshake.
- Add/sub complete in one cycle; multiply/divide iterate one bit per cycle.
- Sits between the operand registers and the result bus of the datapath; replaces the old fixed 4-bit add/sub path and the shift-only multiply/divide.

Parameters:
- WIDTH, 8, operand width in bits (>= 2); result is 2*WIDTH split over result_hi/result_lo.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 add, 01 sub, 10 mul, 11 div; captured with start.
- a  input  WIDTH  operand A / dividend; captured with start.
- b  input  WIDTH  operand B / divisor; captured with start.
- busy  output  1  high while an iterative op is in CALC.
- done  output  1  one-cycle pulse: results valid.
- result_lo  output  WIDTH  sum / difference / product[WIDTH-1:0] / quotient.
- result_hi  output  WIDTH  0 for add/sub / product[2W-1:W] / remainder.
- carry  output  1  add: carry-out; sub: no-borrow (1 iff a >= b); 0 for mul/div.
- div_zero  output  1  set for a divide with b == 0; 0 otherwise.

Behaviour:
- Reset: rst_n low at a rising edge -> state IDLE, counter 0; busy, done, carry, div_zero, result_lo, result_hi all 0. Reset overrides everything, including mid-CALC. An aborted op produces no done.
- States: IDLE, CALC.
- Accept: start=1 in IDLE at edge k captures op/a/b. start in CALC is ignored. No queueing.
- Add/sub, at edge k:
  - Results registered at edge k; state stays IDLE; done=1 for the cycle after edge k.
  - Sub is a + ~b + 1. carry is the WIDTH-th bit of that sum.
  - Wrap-around modulo 2^WIDTH.
- Mul/div with b != 0, at edge k:
  - State -> CALC, busy=1, counter=0.
  - Each CALC edge performs one iteration and increments counter.
  - The edge where counter reaches WIDTH-1 performs the last iteration, registers the results, returns to IDLE and pulses done. So done is high in the cycle after edge k+WIDTH, and busy falls with done.
- Mul: unsigned shift-add, LSB of multiplier first. Exact 2*WIDTH product, no overflow.
- Div: unsigned restoring division, MSB first. Quotient in result_lo, remainder in result_hi, with remainder < b.
- Div with b == 0: no CALC. At edge k: result_lo = all ones, result_hi = a, div_zero=1, carry=0, done the next cycle (same timing as add/sub).
- Results and flags hold their last values until the next accepted start.
  - For iterative ops they may change only on the final CALC edge.
  - Intermediate partial values never appear on result_lo/result_hi.
- Back-to-back: start may be high in the done cycle. It is accepted at that edge (state is IDLE), giving a sustained rate of 1 op/cycle for add/sub.
- done never asserts without a preceding accept. done and busy are never both 1.

Test Plan:
- WIDTH=8, add a=200 b=100 -> next cycle done=1, result_lo=0x2C, result_hi=0, carry=1. Then sub a=5 b=7 -> result_lo=0xFE, carry=0. Then sub a=7 b=5 -> result_lo=0x02, carry=1.
- Mul a=255 b=255 -> busy for 8 cycles; done exactly 8 cycles after the accepting edge; result_hi=0xFE, result_lo=0x01.
- Div a=200 b=7 -> done 8 cycles after accept; result_lo=28, result_hi=4, div_zero=0. Div a=5 b=9 -> quotient 0, remainder 5.
- Div a=0x3C b=0 -> done 1 cycle after accept; result_lo=0xFF, result_hi=0x3C, div_zero=1, busy never high.
- Mul a=13 b=11 in progress:
  - Pulse start with add in cycle 3 of CALC -> ignored; result 143 (hi=0, lo=0x8F) delivered on time.
  - Then drive rst_n low in the 4th CALC cycle of a new mul -> next edge all outputs 0, no done; after release an add 1+1 returns 2.
- Back-to-back adds with start held high 4 cycles (a=i, b=1 for i=0..3) -> done high 4 consecutive cycles with result_lo 1,2,3,4.

Source files
------------

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/mul/div.
// Add/sub finish in one cycle; mul/div take one bit per cycle.
module seq_arith_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mul;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_carry;
  logic             r_dz;
  logic             r_done;

  logic             w_iter;
  logic             w_last;
  logic             w_b_zero;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_rsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rdif;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;

  assign w_b_zero = (b == '0);
  assign w_iter   = start && op[1] && !(op == OP_DIV && w_b_zero);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_add = {1'b0, a} + {1'b0, b};
  assign w_sub = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  // Multiply step: add multiplicand if multiplier LSB set, shift right.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide step: shift next dividend bit into remainder, trial subtract.
  assign w_rsh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_rsh >= {1'b0, r_b});
  assign w_rdif = w_rsh[WIDTH-1:0] - r_b;

  // Next working pair for the active iterative op.
  always_comb begin
    w_nhi = '0;
    w_nlo = '0;
    if (r_mul) begin
      w_nhi = w_msum[WIDTH:1];
      w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_nhi = w_ge ? w_rdif : w_rsh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // Next-state logic.
  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:  if (w_iter) w_nstate = S_CALC;
      S_CALC:  if (w_last) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Outputs from state and result registers.
  always_comb begin
    busy      = (r_state == S_CALC);
    done      = r_done;
    result_lo = r_res_lo;
    result_hi = r_res_hi;
    carry     = r_carry;
    div_zero  = r_dz;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mul    <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_carry  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          unique case (op)
            OP_ADD: begin
              r_res_lo <= w_add[WIDTH-1:0];
              r_res_hi <= '0;
              r_carry  <= w_add[WIDTH];
              r_dz     <= 1'b0;
              r_done   <= 1'b1;
            end
            OP_SUB: begin
              r_res_lo <= w_sub[WIDTH-1:0];
              r_res_hi <= '0;
              r_carry  <= w_sub[WIDTH];
              r_dz     <= 1'b0;
              r_done   <= 1'b1;
            end
            OP_MUL, OP_DIV: begin
              if (op == OP_DIV && w_b_zero) begin
                r_res_lo <= '1;
                r_res_hi <= a;
                r_carry  <= 1'b0;
                r_dz     <= 1'b1;
                r_done   <= 1'b1;
              end else begin
                r_mul <= !op[0];
                r_b   <= b;
                r_hi  <= '0;
                r_lo  <= a;
                r_cnt <= '0;
              end
            end
            default: ;
          endcase
        end
      end else begin
        r_hi  <= w_nhi;
        r_lo  <= w_nlo;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_res_lo <= w_nlo;
          r_res_hi <= w_nhi;
          r_carry  <= 1'b0;
          r_dz     <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// tb_seq_arith_unit: directed vectors with a queue scoreboard.
// A negedge monitor pops expectations whenever done is seen.
module tb_seq_arith_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;
  logic         carry;
  logic         div_zero;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         c;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .carry(carry), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cyc=%0d lo=%h hi=%h",
                 cyc, result_lo, result_hi);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (result_lo !== e.lo || result_hi !== e.hi ||
            carry !== e.c || div_zero !== e.dz) begin
          errors++;
          $display("FAIL result got lo=%h hi=%h c=%b dz=%b exp lo=%h hi=%h c=%b dz=%b",
                   result_lo, result_hi, carry, div_zero,
                   e.lo, e.hi, e.c, e.dz);
        end
        checks++;
        if (cyc != e.due) begin
          errors++;
          $display("FAIL latency got cyc=%0d exp cyc=%0d", cyc, e.due);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL done_with_busy got busy=%b exp 0", busy);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] elo,
                       input logic [W-1:0] ehi, input logic ec,
                       input logic edz, input int lat);
    exp_t e;
    e.lo  = elo;
    e.hi  = ehi;
    e.c   = ec;
    e.dz  = edz;
    e.due = cyc + 1 + lat;
    sbq.push_back(e);
    drive(o, x, y);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d exp 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs",
        {busy, done, carry, div_zero, result_lo, result_hi}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 8'd200, 8'd100, 8'h2C, 8'h00, 1'b1, 1'b0, 0);
    issue(2'b01, 8'd5,   8'd7,   8'hFE, 8'h00, 1'b0, 1'b0, 0);
    issue(2'b01, 8'd7,   8'd5,   8'h02, 8'h00, 1'b1, 1'b0, 0);
    start = 1'b0;
    drain();

    issue(2'b10, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 1'b0, W);
    start = 1'b0;
    chk("mul_busy", {31'd0, busy}, 32'd1);
    drain();

    issue(2'b11, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, W);
    start = 1'b0;
    chk("div_busy", {31'd0, busy}, 32'd1);
    drain();
    issue(2'b11, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0, W);
    start = 1'b0;
    drain();

    issue(2'b11, 8'h3C, 8'd0, 8'hFF, 8'h3C, 1'b0, 1'b1, 0);
    start = 1'b0;
    chk("div0_busy", {31'd0, busy}, 32'd0);
    drain();

    issue(2'b10, 8'd13, 8'd11, 8'h8F, 8'h00, 1'b0, 1'b0, W);
    start = 1'b0;
    repeat (2) @(negedge clk);
    drive(2'b00, 8'd9, 8'd9);
    start = 1'b0;
    drain();

    drive(2'b10, 8'd13, 8'd11);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outs",
        {busy, done, carry, div_zero, result_lo, result_hi}, 32'h0);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    issue(2'b00, 8'd1, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0, 0);
    start = 1'b0;
    drain();

    for (int i = 0; i < 4; i++)
      issue(2'b00, W'(i), 8'd1, W'(i + 1), 8'd0, 1'b0, 1'b0, 0);
    start = 1'b0;
    drain();

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
